// File: rtl/keypad_scanner_4x4.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scanner_4x4
// Description : Reader for a 4x4 matrix keypad. Drives one column low at a
//               time, samples the active-low rows through a 2-flop
//               synchronizer, debounces press and release, decodes the key
//               to a hex nibble and emits one single-cycle strobe per press.
// Ports       : clk         - system clock
//               rst         - synchronous reset, active-high
//               fil[3:0]    - row inputs, active-low, bit i = row i
//               col[3:0]    - column drive, one-cold, bit j = column j
//               key_code    - decoded key, qualify with key_valid/key_pressed
//               key_valid   - one-cycle strobe for each accepted press
//               key_pressed - high from acceptance until release accepted
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scanner_4x4 #(
    parameter int SCAN_DIV   = 50000,
    parameter int DEBOUNCE_N = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] fil,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_pressed
);

    localparam int                SLOT_W    = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int                CNT_W     = $clog2(DEBOUNCE_N + 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_N);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HELD     = 2'd2
    } state_t;

    // Keypad legend, (row, column) -> hex nibble.
    function automatic logic [3:0] f_decode(input logic [1:0] row, input logic [1:0] cidx);
        logic [3:0] code;
        case ({row, cidx})
            4'b00_00: code = 4'h1;
            4'b00_01: code = 4'h2;
            4'b00_10: code = 4'h3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'h4;
            4'b01_01: code = 4'h5;
            4'b01_10: code = 4'h6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'h7;
            4'b10_01: code = 4'h8;
            4'b10_10: code = 4'h9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = 4'hE;
            4'b11_01: code = 4'h0;
            4'b11_10: code = 4'hF;
            default:  code = 4'hD;
        endcase
        return code;
    endfunction

    state_t            r_state;
    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic [SLOT_W-1:0] r_slot;
    logic [1:0]        r_col_idx;
    logic [1:0]        r_row;
    logic [3:0]        r_code_lat;
    logic [CNT_W-1:0]  r_cnt;
    logic [3:0]        r_key_code;
    logic              r_key_valid;
    logic              r_key_pressed;

    state_t            w_state_nxt;
    logic [1:0]        w_col_idx_nxt;
    logic [1:0]        w_row_nxt;
    logic [3:0]        w_code_lat_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [3:0]        w_key_code_nxt;
    logic              w_key_valid_nxt;
    logic              w_key_pressed_nxt;
    logic              w_sample;
    logic              w_any_low;
    logic [1:0]        w_hit_row;
    logic [CNT_W-1:0]  w_cnt_inc;

    assign w_sample  = (r_slot == SLOT_LAST);
    assign w_any_low = (r_sync2 != 4'hF);
    assign w_cnt_inc = r_cnt + 1'b1;

    // Lowest-numbered low row wins when several rows are low together.
    always_comb begin
        w_hit_row = 2'd3;
        if (!r_sync2[2]) w_hit_row = 2'd2;
        if (!r_sync2[1]) w_hit_row = 2'd1;
        if (!r_sync2[0]) w_hit_row = 2'd0;
    end

    always_comb begin
        col = 4'b1110;
        case (r_col_idx)
            2'd0:    col = 4'b1110;
            2'd1:    col = 4'b1101;
            2'd2:    col = 4'b1011;
            default: col = 4'b0111;
        endcase
    end

    // Slot timer runs free; every decision happens only on its last count.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 4'hF;
            r_sync2 <= 4'hF;
            r_slot  <= '0;
        end else begin
            r_sync1 <= fil;
            r_sync2 <= r_sync1;
            r_slot  <= w_sample ? '0 : r_slot + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_SCAN;
            r_col_idx     <= 2'd0;
            r_row         <= 2'd0;
            r_code_lat    <= 4'h0;
            r_cnt         <= '0;
            r_key_code    <= 4'h0;
            r_key_valid   <= 1'b0;
            r_key_pressed <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_col_idx     <= w_col_idx_nxt;
            r_row         <= w_row_nxt;
            r_code_lat    <= w_code_lat_nxt;
            r_cnt         <= w_cnt_nxt;
            r_key_code    <= w_key_code_nxt;
            r_key_valid   <= w_key_valid_nxt;
            r_key_pressed <= w_key_pressed_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_col_idx_nxt     = r_col_idx;
        w_row_nxt         = r_row;
        w_code_lat_nxt    = r_code_lat;
        w_cnt_nxt         = r_cnt;
        w_key_code_nxt    = r_key_code;
        w_key_valid_nxt   = 1'b0;
        w_key_pressed_nxt = r_key_pressed;

        case (r_state)
            ST_SCAN: begin
                if (w_sample) begin
                    if (w_any_low) begin
                        // Column stays frozen on the column that showed the key.
                        w_row_nxt      = w_hit_row;
                        w_code_lat_nxt = f_decode(w_hit_row, r_col_idx);
                        w_cnt_nxt      = '0;
                        w_state_nxt    = ST_DEBOUNCE;
                    end else begin
                        w_col_idx_nxt = r_col_idx + 2'd1;
                    end
                end
            end
            ST_DEBOUNCE: begin
                if (w_sample) begin
                    if (!r_sync2[r_row]) begin
                        if (w_cnt_inc == CNT_DONE) begin
                            w_key_valid_nxt   = 1'b1;
                            w_key_code_nxt    = r_code_lat;
                            w_key_pressed_nxt = 1'b1;
                            w_cnt_nxt         = '0;
                            w_state_nxt       = ST_HELD;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_state_nxt   = ST_SCAN;
                        w_col_idx_nxt = r_col_idx + 2'd1;
                    end
                end
            end
            ST_HELD: begin
                // Counter now counts consecutive all-released samples; any
                // low row (including a second key) restarts it.
                if (w_sample) begin
                    if (!w_any_low) begin
                        if (w_cnt_inc == CNT_DONE) begin
                            w_key_pressed_nxt = 1'b0;
                            w_cnt_nxt         = '0;
                            w_state_nxt       = ST_SCAN;
                            w_col_idx_nxt     = r_col_idx + 2'd1;
                        end else begin
                            w_cnt_nxt = w_cnt_inc;
                        end
                    end else begin
                        w_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_SCAN;
            end
        endcase
    end

    assign key_code    = r_key_code;
    assign key_valid   = r_key_valid;
    assign key_pressed = r_key_pressed;

endmodule
`default_nettype wire

// File: doc/keypad_scanner_4x4.md
Name: keypad_scanner_4x4

Overview:
- Reader side of the 4x4 matrix keypad interface that feeds operands into the divider top.
- Drives the column lines active-low and samples the active-low row lines through a synchronizer.
- Debounces, decodes the pressed key to a hex nibble, and emits exactly one single-cycle strobe per physical press.
- Its outputs feed the nibble-assembly logic that builds the A and B operands.

Parameters:
- SCAN_DIV, 50000: clk cycles each column stays driven; also the sample period in the DEBOUNCE and HELD states. Must be >= 4.
- DEBOUNCE_N, 3: consecutive matching samples needed to accept a press, and consecutive all-high samples needed to accept a release. Must be >= 1.

Ports:
- clk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- fil  in  4  keypad row inputs, active-low, pulled up. Bit i = row i.
- col  out 4  keypad column drive, one-cold (one bit low at a time). Bit j = column j.
- key_code  out 4  decoded key; only meaningful while key_valid is high or key_pressed is high.
- key_valid  out 1  one-cycle strobe marking a new accepted press.
- key_pressed  out 1  level signal, high from acceptance until release is accepted.

Behaviour:
- Reset (rst high on a clk edge):
  - col=4'b1110, key_code=0, key_valid=0, key_pressed=0.
  - state=SCAN, slot counter=0, debounce counter=0, synchronizer flops=4'hF.
  - Reset mid-DEBOUNCE or mid-HELD aborts with no key_valid pulse.
- Input path: fil passes through a 2-flop synchronizer (fil_s), adding 2 cycles of latency. All decisions use fil_s.
- Slot timer: counts 0..SCAN_DIV-1. The "sample" point is the cycle where the count equals SCAN_DIV-1.
- Key map, (row,col) -> code:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: *=E, 0=0, #=F, D=D
- Multiple rows low at one sample: the lowest row index wins.
- State SCAN:
  - col rotates 1110 -> 1101 -> 1011 -> 0111 -> 1110, advancing one step each sample point.
  - At a sample point with fil_s != 4'hF: latch row, col and code; hold col frozen; clear the debounce counter; go to DEBOUNCE.
- State DEBOUNCE:
  - At each sample point, check whether the latched row bit is still low.
  - If it is: increment the debounce counter. When the counter reaches DEBOUNCE_N, key_valid=1 for the next single cycle, key_code=latched code, key_pressed=1, go to HELD.
  - If it is not: go to SCAN, with col advancing to the next column at that edge.
- State HELD:
  - col stays frozen; key_code holds its value; no auto-repeat.
  - At each sample point: if fil_s==4'hF, increment the release counter; otherwise clear it.
  - When the release counter reaches DEBOUNCE_N: key_pressed=0, go to SCAN, col advances to the next column.
- Latency: key_valid rises 1 cycle after the DEBOUNCE_N-th confirm sample, i.e. DEBOUNCE_N*SCAN_DIV+1 cycles after the detecting sample, plus 2 synchronizer cycles relative to the pin.
- Simultaneous events: rst has priority over everything. A second key pressed while HELD is ignored until release is accepted.
- key_code is unchanged after release, but consumers must qualify it with key_valid or key_pressed.

Test Plan:
Common bench setup:
- SCAN_DIV=4, DEBOUNCE_N=2.
- The bench models the keypad: for the pressed key at (r,c), fil[r]=0 only while col[c]==0; all other fil bits are 1.

Scenarios:
1. Reset and rotation: hold rst 8 cycles, then release.
   - col=1110 during reset.
   - After release, col steps 1110,1101,1011,0111 every 4 cycles (period 16).
   - key_valid=0 and key_pressed=0 throughout.
2. Single press "5" (r1,c1), held 80 cycles, then released.
   - Exactly one key_valid pulse, with key_code=4'h5.
   - key_pressed high from the pulse cycle until 2 clean samples (+2 sync cycles) after release.
   - col resumes rotation after release.
3. Glitch: "9" asserted for 3 cycles straddling a single sample point.
   - State returns to SCAN at the next sample.
   - No key_valid pulse; col rotation continues.
4. Mapping sweep: press D, *, 0, #, A in sequence, each held 80 cycles with 80 idle cycles between.
   - key_valid pulses with codes D, E, 0, F, A, in that order.
5. Two keys in column 0 (rows 0 and 2) pressed together.
   - One pulse, with key_code=4'h1.
6. Reset mid-operation: press "7", assert rst for 1 cycle during DEBOUNCE (after the first confirm sample).
   - No key_valid pulse.
   - col=1110 on the following cycle.
   - If the key is still held, a fresh full detect plus debounce then yields key_code=4'h7.
